// File: rtl/cmd_stream_arbiter.sv
// ---------------------------------------------------------------------------
// cmd_stream_arbiter
//
// Merges two byte-oriented command streams (for example SPI and UART) onto
// one stream feeding the command decoder. Whole commands are forwarded
// atomically. The first byte of each command is the opcode, and it sets how
// many bytes that command has. The arbiter locks onto the source that sent
// the opcode until the last byte of the command has transferred.
//
// The data path is a zero-latency combinational mux. Only the arbitration
// state is registered.
//
// Parameters
//   TRI_CMD_BYTES  : total bytes of an 0xA1 upload-triangle command (<= 255)
//   INST_CMD_BYTES : total bytes of an 0xB0 add-model-instance command (<= 255)
//
// Ports
//   clk, rstn                    : clock (rising edge), async active-low reset
//   s0_valid/s0_ready/s0_data    : source 0 byte stream
//   s1_valid/s1_ready/s1_data    : source 1 byte stream
//   m_valid/m_ready/m_data       : merged stream to the command decoder
//   m_src                        : index of the source currently granted
//   busy                         : high while a multi-byte command is open
//   bad_opcode                   : one-cycle pulse after an unknown opcode
//                                  has been forwarded
//
// Optional feature (macro CMD_ARB_STATS_EN)
//   s0_cmd_count, s1_cmd_count   : 16-bit wrapping count of commands each
//                                  source has completed
// ---------------------------------------------------------------------------
module cmd_stream_arbiter #(
    parameter int TRI_CMD_BYTES  = 19,
    parameter int INST_CMD_BYTES = 14
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s0_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    input  logic [7:0] s1_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_src,
    output logic       busy,
    output logic       bad_opcode
`ifdef CMD_ARB_STATS_EN
    ,
    output logic [15:0] s0_cmd_count,
    output logic [15:0] s1_cmd_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;     // source owning the open command
    logic       rr_q, rr_d;           // tie-break winner when both sources request
    logic [7:0] bytes_left_q, bytes_left_d;
    logic       bad_q, bad_d;

    logic       grant;
    logic       xfer;
    logic       cmd_last;             // the current transfer completes a command
    logic [7:0] cmd_len;

    // Total length of a command, opcode byte included. Any opcode that is not
    // recognised is treated as a one-byte command. This keeps the arbiter from
    // locking up on garbage bytes.
    function automatic logic [7:0] opcode_len(input logic [7:0] op);
        case (op)
            8'hA0:   opcode_len = 8'd2;
            8'hA1:   opcode_len = 8'(TRI_CMD_BYTES);
            8'hB0:   opcode_len = 8'(INST_CMD_BYTES);
            default: opcode_len = 8'd1;
        endcase
    endfunction

    function automatic logic opcode_known(input logic [7:0] op);
        opcode_known = (op == 8'hA0) || (op == 8'hA1) || (op == 8'hB0);
    endfunction

    // Grant selection. In LOCKED the owner is held even when it stops
    // requesting, so that the other source never splits a command.
    always_comb begin
        grant = rr_q;
        if (state_q == LOCKED) begin
            grant = grant_q;
        end else if (s0_valid && !s1_valid) begin
            grant = 1'b0;
        end else if (s1_valid && !s0_valid) begin
            grant = 1'b1;
        end
    end

    assign m_valid  = grant ? s1_valid : s0_valid;
    assign m_data   = grant ? s1_data  : s0_data;
    assign s0_ready = !grant && m_ready;
    assign s1_ready =  grant && m_ready;
    assign m_src    = grant;
    assign busy     = (state_q == LOCKED);
    assign bad_opcode = bad_q;

    assign xfer    = m_valid && m_ready;
    assign cmd_len = opcode_len(m_data);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        bytes_left_d = bytes_left_q;
        bad_d        = 1'b0;
        cmd_last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (cmd_len > 8'd1) begin
                        bytes_left_d = cmd_len - 8'd1;
                        state_d      = LOCKED;
                        grant_d      = grant;
                    end else begin
                        rr_d     = !grant;
                        bad_d    = !opcode_known(m_data);
                        cmd_last = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    bytes_left_d = bytes_left_q - 8'd1;
                    if (bytes_left_q == 8'd1) begin
                        state_d  = IDLE;
                        rr_d     = !grant_q;
                        cmd_last = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset in the middle of a command drops the partial command. The
    // decoder shares rstn, so it discards its own partial state as well.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            rr_q         <= 1'b0;
            bytes_left_q <= 8'd0;
            bad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            bytes_left_q <= bytes_left_d;
            bad_q        <= bad_d;
        end
    end

`ifdef CMD_ARB_STATS_EN
    logic [15:0] s0_cnt_q, s0_cnt_d;
    logic [15:0] s1_cnt_q, s1_cnt_d;

    // The counters wrap naturally at 16 bits.
    always_comb begin
        s0_cnt_d = s0_cnt_q;
        s1_cnt_d = s1_cnt_q;
        if (xfer && cmd_last) begin
            if (grant) s1_cnt_d = s1_cnt_q + 16'd1;
            else       s0_cnt_d = s0_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_cnt_q <= 16'd0;
            s1_cnt_q <= 16'd0;
        end else begin
            s0_cnt_q <= s0_cnt_d;
            s1_cnt_q <= s1_cnt_d;
        end
    end

    assign s0_cmd_count = s0_cnt_q;
    assign s1_cmd_count = s1_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cmd_stream_arbiter.
// Each source is fed from a byte queue. Every merged-stream transfer is
// compared against a scoreboard of {src, data} values that the bench filled
// in the order the arbiter is required to produce them.
// ---------------------------------------------------------------------------
module tb_cmd_stream_arbiter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
    logic       s0_ready, s1_ready, m_valid, m_src, busy, bad_opcode;
    logic [7:0] m_data;
`ifdef CMD_ARB_STATS_EN
    logic [15:0] s0_cmd_count, s1_cmd_count;
`endif

    cmd_stream_arbiter #(.TRI_CMD_BYTES(19), .INST_CMD_BYTES(14)) dut (
        .clk(clk), .rstn(rstn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_src(m_src), .busy(busy), .bad_opcode(bad_opcode)
`ifdef CMD_ARB_STATS_EN
        , .s0_cmd_count(s0_cmd_count), .s1_cmd_count(s1_cmd_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [8:0] sb[$];
    logic fire0 = 1'b0, fire1 = 1'b0;
    int xfers = 0;
    int bad_seen = 0;
    int exp_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source drivers: present the head of each queue and retire it after an
    // accepted transfer.
    initial forever begin
        @(posedge clk);
        #1;
        if (fire0 && q0.size() > 0) void'(q0.pop_front());
        if (fire1 && q1.size() > 0) void'(q1.pop_front());
        s0_valid = (q0.size() > 0);
        s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        s1_valid = (q1.size() > 0);
        s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    end

    // Monitor: samples late in the low phase, just before the active edge.
    initial forever begin
        logic [31:0] exp;
        @(negedge clk);
        #3;
        fire0 = rstn && s0_valid && s0_ready;
        fire1 = rstn && s1_valid && s1_ready;
        if (bad_opcode) bad_seen++;
        if (rstn && m_valid && m_ready) begin
            xfers++;
            exp = (sb.size() > 0) ? {23'd0, sb.pop_front()} : 32'hDEAD_BEEF;
            check_eq("xfer", {23'd0, m_src, m_data}, exp);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] b, input logic exp_in_sb);
        q0.push_back(b);
        if (exp_in_sb) sb.push_back({1'b0, b});
    endtask

    task automatic push1(input logic [7:0] b);
        q1.push_back(b);
        sb.push_back({1'b1, b});
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) break;
            step();
        end
        check_eq(tag, 32'(q0.size() + q1.size() + sb.size()), 32'd0);
    endtask

    logic [7:0] tri_cmd[19];
    logic [7:0] held;
    int start;

    initial begin
        for (int i = 0; i < 19; i++) tri_cmd[i] = (i == 0) ? 8'hA1 : 8'(i * 7 + 3);

        repeat (3) step();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_bad", bad_opcode, 1'b0);
        check_eq("rst_msrc", m_src, 1'b0);
        check_eq("rst_mvalid", m_valid, 1'b0);
        rstn = 1'b1;
        m_ready = 1'b1;
        #1;
        check_eq("rel_msrc", m_src, 1'b0);
        check_eq("rel_mvalid", m_valid, 1'b0);

        // Two-byte command from s0 alone.
        push0(8'hA0, 1'b1);
        push0(8'h05, 1'b1);
        step();
        check_eq("t1_data0", m_data, 8'hA0);
        check_eq("t1_busy0", busy, 1'b0);
        step();
        check_eq("t1_busy1", busy, 1'b1);
        check_eq("t1_data1", m_data, 8'h05);
        check_eq("t1_src1", m_src, 1'b0);
        step();
        check_eq("t1_busy2", busy, 1'b0);
        check_eq("t1_rr", m_src, 1'b1);
        drain("t1_drain", 10);

        // Both sources requesting when reset is released.
        step();
        rstn = 1'b0;
        m_ready = 1'b0;
        push0(8'hA0, 1'b1); push0(8'h07, 1'b1);
        push1(8'hA0); push1(8'h09);
        step();
        check_eq("t2_rst_src", m_src, 1'b0);
        check_eq("t2_rst_mvalid", m_valid, 1'b1);
        rstn = 1'b1;
        m_ready = 1'b1;
        #1;
        check_eq("t2_s1rdy0", s1_ready, 1'b0);
        check_eq("t2_data0", m_data, 8'hA0);
        step();
        check_eq("t2_s1rdy1", s1_ready, 1'b0);
        check_eq("t2_data1", m_data, 8'h07);
        step();
        check_eq("t2_s1rdy2", s1_ready, 1'b1);
        check_eq("t2_src2", m_src, 1'b1);
        drain("t2_drain", 20);

        // Unknown opcode: single-byte forward, pulse, turn passes to s1.
        push0(8'h55, 1'b1);
        push1(8'hA0); push1(8'h11);
        push0(8'hA0, 1'b1); push0(8'h22, 1'b1);
        exp_bad++;
        step();
        check_eq("t3_data", m_data, 8'h55);
        check_eq("t3_src", m_src, 1'b0);
        step();
        check_eq("t3_bad1", bad_opcode, 1'b1);
        check_eq("t3_busy", busy, 1'b0);
        check_eq("t3_next", m_src, 1'b1);
        step();
        check_eq("t3_bad2", bad_opcode, 1'b0);
        drain("t3_drain", 20);

        // s1 stalls mid-B0 while s0 waits; s0 must stay locked out.
        push1(8'hB0);
        for (int i = 1; i < 5; i++) push1(8'(i));
        step();
        check_eq("t4_src", m_src, 1'b1);
        q0.push_back(8'hA0); q0.push_back(8'h33);
        for (int i = 0; i < 20; i++) begin
            if (q1.size() == 0) break;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_s0rdy", s0_ready, 1'b0);
            check_eq("t4_mvalid", m_valid, 1'b0);
            check_eq("t4_busy", busy, 1'b1);
            step();
        end
        for (int i = 5; i < 14; i++) push1(8'(i));
        sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b0, 8'h33});
        drain("t4_drain", 40);

        // Downstream stall in the middle of an A1 command.
        start = xfers;
        for (int i = 0; i < 19; i++) push0(tri_cmd[i], 1'b1);
        for (int i = 0; i < 50 && xfers < start + 6; i++) step();
        check_eq("t5_reach", 32'(xfers), 32'(start + 6));
        m_ready = 1'b0;
        #1;
        held = m_data;
        check_eq("t5_held", held, tri_cmd[6]);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t5_stable", m_data, tri_cmd[6]);
            check_eq("t5_left", dut.bytes_left_q, 8'd13);
            check_eq("t5_busy", busy, 1'b1);
        end
        check_eq("t5_noxfer", 32'(xfers), 32'(start + 6));
        m_ready = 1'b1;
        drain("t5_drain", 60);
        check_eq("t5_count", 32'(xfers - start), 32'd19);

        // Reset after byte 3 of an A1 command.
        start = xfers;
        for (int i = 0; i < 19; i++) push0(tri_cmd[i], i < 3);
        for (int i = 0; i < 50 && xfers < start + 3; i++) step();
        check_eq("t6_reach", 32'(xfers), 32'(start + 3));
        rstn = 1'b0;
        m_ready = 1'b0;
        q0.delete();
        #1;
        check_eq("t6_busy_rst", busy, 1'b0);
        step();
        step();
        rstn = 1'b1;
        m_ready = 1'b1;
        #1;
        check_eq("t6_busy_rel", busy, 1'b0);
        check_eq("t6_src_rel", m_src, 1'b0);
        push0(8'hA0, 1'b1); push0(8'h44, 1'b1);
        step();
        check_eq("t6_op", m_data, 8'hA0);
        step();
        check_eq("t6_busy_op", busy, 1'b1);
        check_eq("t6_arg", m_data, 8'h44);
        drain("t6_drain", 20);

`ifdef CMD_ARB_STATS_EN
        check_eq("st_s0", s0_cmd_count, 16'd1);
        check_eq("st_s1", s1_cmd_count, 16'd0);
        for (int i = 0; i < 65535; i++) push0(8'h55, 1'b1);
        exp_bad += 65535;
        drain("st_drain", 70000);
        check_eq("st_wrap", s0_cmd_count, 16'd0);
`endif

        step();
        step();
        check_eq("bad_total", 32'(bad_seen), 32'(exp_bad));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_stream_arbiter.md
CMD_STREAM_ARBITER -- requirements
Module: cmd_stream_arbiter

Interface
REQ-001 SHALL have parameter TRI_CMD_BYTES, default 19, total bytes (opcode included) of an 0xA1 upload-triangle command.
REQ-002 SHALL have parameter INST_CMD_BYTES, default 14, total bytes (opcode included) of an 0xB0 add-model-instance command.
REQ-003 SHALL have ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  reset, asynchronous, active-low
s0_valid / s0_ready / s0_data  in / out / in  1/1/8  source 0 byte stream (e.g. SPI)
s1_valid / s1_ready / s1_data  in / out / in  1/1/8  source 1 byte stream (e.g. UART)
m_valid / m_ready / m_data  out / in / out  1/1/8  merged stream to command decoder
m_src  out  1  index of source currently driving m_*
busy  out  1  high while a multi-byte command is mid-transfer
bad_opcode  out  1  one-cycle pulse when an unrecognised opcode is forwarded

Function
REQ-004 SHALL forward whole commands atomically: bytes of two commands never interleave on m_*.
REQ-005 SHALL be zero-latency combinational pass-through: m_valid = valid of granted source, m_data = its data, granted s_ready = m_ready; non-granted s_ready = 0.
REQ-006 SHALL implement states IDLE and LOCKED; reset state IDLE.
REQ-007 In IDLE, grant SHALL go to the only valid source; if both valid, to source rr_ptr; if none valid, grant = rr_ptr, m_valid = 0.
REQ-008 On IDLE transfer (m_valid & m_ready), opcode length SHALL be decoded: 0xA0 -> 2, 0xA1 -> TRI_CMD_BYTES, 0xB0 -> INST_CMD_BYTES, other -> 1.
REQ-009 If decoded length > 1: bytes_left <= length-1, state <= LOCKED, grant held to that source.
REQ-010 If decoded length = 1: state stays IDLE, rr_ptr <= other source, bad_opcode pulses next cycle for unknown opcodes.
REQ-011 In LOCKED, each transfer SHALL decrement bytes_left; transfer with bytes_left = 1 returns to IDLE and sets rr_ptr to the other source.
REQ-012 In LOCKED, the other source SHALL be held off indefinitely, even if locked source deasserts valid (no timeout).
REQ-013 Stall (m_ready = 0) SHALL hold bytes_left, state, grant; m_data stable while granted source holds data.
REQ-014 bytes_left SHALL be 8 bits; parameters above 255 are illegal.
REQ-015 busy = (state == LOCKED); m_src = current grant.

Reset
REQ-016 rstn low SHALL immediately force: state IDLE, rr_ptr 0, bytes_left 0, bad_opcode 0, stats 0; m_valid = s0_valid and m_src = 0 during reset-released IDLE with no requests.
REQ-017 Reset mid-command SHALL discard the partial command; the downstream decoder is reset by the same rstn.

Configuration
REQ-018 Macro CMD_ARB_STATS_EN: when defined, SHALL add outputs s0_cmd_count and s1_cmd_count (16 bits each, wrap at 0xFFFF -> 0) incremented on last byte of every forwarded command of that source.
REQ-019 Without CMD_ARB_STATS_EN, these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-020 s0 sends A0 05 while s1 idle, m_ready=1 -> m_data A0,05 on consecutive cycles, m_src=0, busy high 1 cycle, then rr_ptr=1.
REQ-021 Both valid at reset release, s0 sends A0 07, s1 sends A0 09 -> m_* carries A0 07 A0 09, s1_ready=0 for first 2 cycles.
REQ-022 s1 starts B0 command (14 bytes), drops valid 3 cycles after byte 5 while s0 valid -> s0_ready stays 0 until s1's 14th byte transfers.
REQ-023 s0 sends 0x55 -> one-cycle forward, bad_opcode pulses once, state stays IDLE, next grant goes to s1 if valid.
REQ-024 m_ready low 4 cycles mid A1 command -> no byte lost/duplicated, bytes_left unchanged over stall, exactly 19 bytes forwarded.
REQ-025 rstn asserted after byte 3 of A1 command -> busy=0 immediately, next accepted byte decoded as opcode; with CMD_ARB_STATS_EN, 0x10000 commands from s0 -> s0_cmd_count wraps to 0.
